// File: rtl/clock_pkg.sv
// Shared definitions for the clock time-setting controller: FSM states,
// field codes, per-field limits and wrap-around helpers.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    EDIT_HOUR = 2'd1,
    EDIT_MIN  = 2'd2,
    EDIT_SEC  = 2'd3
  } state_t;

  localparam logic [1:0] FIELD_HOUR = 2'd0;
  localparam logic [1:0] FIELD_MIN  = 2'd1;
  localparam logic [1:0] FIELD_SEC  = 2'd2;

  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] SEC_MAX  = 6'd59;

  // Increment with wrap to 0 past max_v.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max_v);
    return (v == max_v) ? 6'd0 : v + 6'd1;
  endfunction

  // Decrement with wrap from 0 to max_v.
  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max_v);
    return (v == 6'd0) ? max_v : v - 6'd1;
  endfunction

  // Field code shown on field_sel for a given state (RUN reports hour).
  function automatic logic [1:0] field_of(input state_t s);
    case (s)
      EDIT_MIN: return FIELD_MIN;
      EDIT_SEC: return FIELD_SEC;
      default:  return FIELD_HOUR;
    endcase
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button-pulse inputs and time/display outputs of the clock controller.
// master = button/display side, slave = controller.
interface clock_set_ctrl_if;
  logic       L_edge;
  logic       R_edge;
  logic       U_edge;
  logic       D_edge;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       edit_mode;
  logic [1:0] field_sel;
  logic       blink;

  modport master (
    output L_edge, R_edge, U_edge, D_edge,
    input  hour, min, sec, edit_mode, field_sel, blink
  );

  modport slave (
    input  L_edge, R_edge, U_edge, D_edge,
    output hour, min, sec, edit_mode, field_sel, blink
  );
endinterface

// File: rtl/tick_gen.sv
// Modulo-N counter with synchronous clear and enable; tick is high during
// the cycle the counter sits at N-1 while enabled.
module tick_gen #(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count 0..N-1 while enabled; clear has priority over counting.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Timekeeping and time-setting controller: runs HH:MM:SS from a 1 s
// prescaler, and lets the user select and adjust one field in edit mode
// with a 2 Hz blink enable for the selected field.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  clock_set_ctrl_if.slave   ctrl
);

  state_t     state_q, state_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       blink_q, blink_d;
  logic       edit_q;
  logic [1:0] field_q;
  logic       sec_tick;
  logic       blink_tick;
  logic       blink_restart;

  // One-second prescaler: runs only in RUN, held at 0 while editing.
  tick_gen #(.N(CLK_HZ)) u_sec_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != RUN),
    .en   (state_q == RUN),
    .tick (sec_tick)
  );

  // Quarter-second blink timer: idle in RUN, restarted on every field change.
  tick_gen #(.N(CLK_HZ / 4)) u_blink_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state_q == RUN) || blink_restart),
    .en   (state_q != RUN),
    .tick (blink_tick)
  );

  // Next state, time and blink; one button action per cycle, L > R > U > D.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d       = state_q;
    hour_d        = hour_q;
    min_d         = min_q;
    sec_d         = sec_q;
    blink_d       = blink_q;
    blink_restart = 1'b0;

    unique case (state_q)
      RUN: begin
        blink_d = 1'b1;
        if (ctrl.L_edge) begin
          state_d       = EDIT_HOUR;
          blink_restart = 1'b1;
        end else if (sec_tick) begin
          sec_d = wrap_inc(sec_q, SEC_MAX);
          if (sec_q == SEC_MAX) begin
            min_d = wrap_inc(min_q, MIN_MAX);
            if (min_q == MIN_MAX) begin
              hour_d = 5'(wrap_inc({1'b0, hour_q}, HOUR_MAX));
            end
          end
        end
      end
      default: begin
        if (ctrl.L_edge) begin
          state_d = RUN;
          blink_d = 1'b1;
        end else if (ctrl.R_edge) begin
          unique case (state_q)
            EDIT_HOUR: state_d = EDIT_MIN;
            EDIT_MIN:  state_d = EDIT_SEC;
            default:   state_d = EDIT_HOUR;
          endcase
          blink_d       = 1'b1;
          blink_restart = 1'b1;
        end else begin
          if (ctrl.U_edge || ctrl.D_edge) begin
            unique case (state_q)
              EDIT_HOUR: hour_d = ctrl.U_edge ? 5'(wrap_inc({1'b0, hour_q}, HOUR_MAX))
                                              : 5'(wrap_dec({1'b0, hour_q}, HOUR_MAX));
              EDIT_MIN:  min_d  = ctrl.U_edge ? wrap_inc(min_q, MIN_MAX)
                                              : wrap_dec(min_q, MIN_MAX);
              default:   sec_d  = ctrl.U_edge ? wrap_inc(sec_q, SEC_MAX)
                                              : wrap_dec(sec_q, SEC_MAX);
            endcase
          end
          if (blink_tick) begin
            blink_d = ~blink_q;
          end
        end
      end
    endcase
  end

  // State, time and decoded output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      blink_q <= 1'b1;
      edit_q  <= 1'b0;
      field_q <= FIELD_HOUR;
    end else begin
      state_q <= state_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      blink_q <= blink_d;
      edit_q  <= (state_d != RUN);
      field_q <= field_of(state_d);
    end
  end

  assign ctrl.hour      = hour_q;
  assign ctrl.min       = min_q;
  assign ctrl.sec       = sec_q;
  assign ctrl.edit_mode = edit_q;
  assign ctrl.field_sel = field_q;
  assign ctrl.blink     = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl at CLK_HZ = 8. Stimulus pushes
// expected output values tagged with the cycle they must appear on; a
// monitor pops and compares them one time unit after each rising edge.
module tb_clock_set_ctrl;

  localparam int unsigned CLK_HZ = 8;

  typedef enum int { S_HOUR, S_MIN, S_SEC, S_EDIT, S_FIELD, S_BLINK } sig_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  string tag_q[$];
  int    cyc_q[$];
  sig_t  sig_q[$];
  int    val_q[$];

  clock_set_ctrl_if u_if ();

  clock_set_ctrl #(.CLK_HZ(CLK_HZ)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] read_sig(input sig_t s);
    case (s)
      S_HOUR:  return 32'(u_if.hour);
      S_MIN:   return 32'(u_if.min);
      S_SEC:   return 32'(u_if.sec);
      S_EDIT:  return 32'(u_if.edit_mode);
      S_FIELD: return 32'(u_if.field_sel);
      default: return 32'(u_if.blink);
    endcase
  endfunction

  // Expect signal s to equal val on the output seen dly edges from now.
  task automatic sb_push(input string tag, input sig_t s, input int val, input int dly);
    tag_q.push_back(tag);
    cyc_q.push_back(cyc + dly);
    sig_q.push_back(s);
    val_q.push_back(val);
  endtask

  task automatic sb_time(input string tag, input int h, input int m, input int s, input int dly);
    sb_push({tag, "_hour"}, S_HOUR, h, dly);
    sb_push({tag, "_min"},  S_MIN,  m, dly);
    sb_push({tag, "_sec"},  S_SEC,  s, dly);
  endtask

  // Drive one cycle of button inputs, sampled at the next rising edge.
  task automatic tick(input logic l, input logic r, input logic u, input logic d);
    @(negedge clk);
    u_if.L_edge = l;
    u_if.R_edge = r;
    u_if.U_edge = u;
    u_if.D_edge = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare every expectation due on this cycle.
  always @(posedge clk) begin
    cyc++;
    #1;
    for (int i = int'(cyc_q.size()) - 1; i >= 0; i--) begin
      if (cyc_q[i] == cyc) begin
        check(tag_q[i], read_sig(sig_q[i]), 32'(val_q[i]));
        tag_q.delete(i);
        cyc_q.delete(i);
        sig_q.delete(i);
        val_q.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1;
    u_if.L_edge = 1'b0;
    u_if.R_edge = 1'b0;
    u_if.U_edge = 1'b0;
    u_if.D_edge = 1'b0;
    idle(3);

    // Reset release: reset state, first second exactly 8 cycles later.
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    sb_time("rst", 0, 0, 0, 1);
    sb_push("rst_edit",  S_EDIT,  0, 1);
    sb_push("rst_field", S_FIELD, 0, 1);
    sb_push("rst_blink", S_BLINK, 1, 1);
    sb_push("first_sec_pre", S_SEC, 0, 7);
    sb_push("first_sec",     S_SEC, 1, 8);
    idle(9);

    // Reset mid-count, then the prescaler restarts from 0.
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    sb_push("midrst_sec", S_SEC, 0, 1);
    idle(1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    sb_push("rel2_sec_pre", S_SEC, 0, 7);
    sb_push("rel2_sec",     S_SEC, 1, 8);
    idle(7);

    // Enter edit at 00:00:01; blink pattern 1,1,0,0,1; no counting.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    sb_push("enter_edit",  S_EDIT,  1, 1);
    sb_push("enter_field", S_FIELD, 0, 1);
    sb_push("blink_e1", S_BLINK, 1, 1);
    sb_push("blink_e2", S_BLINK, 1, 2);
    sb_push("blink_e3", S_BLINK, 0, 3);
    sb_push("blink_e4", S_BLINK, 0, 4);
    sb_push("blink_e5", S_BLINK, 1, 5);
    sb_push("blink_e7", S_BLINK, 0, 7);
    sb_push("edit_hold_sec", S_SEC, 1, 6);
    idle(6);

    // R while blink is low: field -> MIN, blink forced high and restarted.
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    sb_push("r_field",       S_FIELD, 1, 1);
    sb_push("blink_force",   S_BLINK, 1, 1);
    sb_push("blink_r2",      S_BLINK, 1, 2);
    sb_push("blink_restart", S_BLINK, 0, 3);

    // U x3 on minutes.
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    sb_push("u1_min", S_MIN, 1, 1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    sb_time("u3", 0, 3, 1, 1);
    sb_push("u3_field", S_FIELD, 1, 1);
    sb_push("edit_nocount_sec", S_SEC, 1, 9);
    sb_push("edit_nocount_mode", S_EDIT, 1, 9);
    idle(8);

    // Minute wraps in both directions, no carry into hour.
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    sb_push("min_wrap_dn", S_MIN, 59, 1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    sb_push("min_wrap_up", S_MIN, 0, 1);
    sb_push("min_wrap_up_hour", S_HOUR, 0, 1);
    tick(1'b0, 1'b0, 0, 1'b1);
    sb_push("min_back_59", S_MIN, 59, 1);

    // Seconds: 1 -> 0 -> 59, U wraps to 0 with minutes untouched, then 58.
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    sb_push("sec_field", S_FIELD, 2, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    sb_push("sec_wrap_dn", S_SEC, 59, 1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    sb_push("sec_wrap_nocarry_sec", S_SEC, 0, 1);
    sb_push("sec_wrap_nocarry_min", S_MIN, 59, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    sb_push("sec_58", S_SEC, 58, 1);

    // Hour: R wraps SEC -> HOUR, D at 0 -> 23.
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    sb_push("hour_field", S_FIELD, 0, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    sb_time("hour_wrap", 23, 59, 58, 1);

    // R + D together: field advances, D dropped.
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    sb_push("rd_field", S_FIELD, 1, 1);
    sb_time("rd", 23, 59, 58, 1);

    // L + U together in EDIT_MIN: back to RUN, minutes untouched, then rollover.
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    sb_push("lu_edit",  S_EDIT,  0, 1);
    sb_push("lu_field", S_FIELD, 0, 1);
    sb_push("lu_blink", S_BLINK, 1, 1);
    sb_time("lu", 23, 59, 58, 1);
    sb_push("roll_pre_sec", S_SEC, 58, 8);
    sb_time("roll_59", 23, 59, 59, 9);
    sb_push("roll_pre0_sec", S_SEC, 59, 16);
    sb_time("roll_00", 0, 0, 0, 17);
    sb_push("roll_hold_sec", S_SEC, 0, 24);
    idle(23);

    // L on the same cycle as a terminal count: mode change wins.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    sb_push("l_tc_sec",  S_SEC,  0, 1);
    sb_push("l_tc_edit", S_EDIT, 1, 1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    sb_push("pre_rst_hour", S_HOUR, 1, 1);

    // Reset during edit discards the partial edit.
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    sb_time("edit_rst", 0, 0, 0, 1);
    sb_push("edit_rst_edit",  S_EDIT,  0, 1);
    sb_push("edit_rst_blink", S_BLINK, 1, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle(3);

    check("drain_pending", 32'(cyc_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
